// File: rtl/pulse_width_meter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_meter
// Description : Measures the number of clock edges a synchronous level input
//               is held high and presents each completed width on a
//               valid/ready result register. Optional stuck-high timeout is
//               enabled with the macro PULSE_METER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_width_meter #(
    parameter int WIDTH_W   = 16,
    parameter int MIN_WIDTH = 1,
    parameter int COUNT_W   = 8
`ifdef PULSE_METER_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 1000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sig,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [WIDTH_W-1:0] width_o,
    output logic               sat_o,
    output logic               overrun_o,
    output logic [COUNT_W-1:0] pulse_count_o
`ifdef PULSE_METER_TIMEOUT_EN
    ,
    output logic               timeout_o
`endif
);

    typedef enum logic [1:0] {
        S_ARM  = 2'd0,
        S_IDLE = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    localparam logic [WIDTH_W-1:0] c_min = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0] c_max = {WIDTH_W{1'b1}};

    state_t               r_state;
    logic [WIDTH_W-1:0]   r_cnt;
    logic                 r_sat;
    logic                 r_valid;
    logic [WIDTH_W-1:0]   r_width;
    logic                 r_sat_out;
    logic                 r_overrun;
    logic [COUNT_W-1:0]   r_pulse_count;

    logic                 w_end;
    logic                 w_tmo;
    logic                 w_keep;
    logic                 w_free;

`ifdef PULSE_METER_TIMEOUT_EN
    localparam logic [WIDTH_W-1:0] c_timeout = WIDTH_W'(TIMEOUT);
    logic                 r_timeout;

    // Timeout fires once the count already equals TIMEOUT and sig is still high.
    assign w_tmo     = (r_state == S_MEAS) && sig && (r_cnt == c_timeout);
    assign timeout_o = r_timeout;
`else
    assign w_tmo     = 1'b0;
`endif

    assign w_end  = (r_state == S_MEAS) && !sig;
    // In both completion cases the width to report is the current count.
    assign w_keep = (w_end || w_tmo) && (r_cnt >= c_min);
    assign w_free = !r_valid || ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_ARM;
            r_cnt         <= '0;
            r_sat         <= 1'b0;
            r_valid       <= 1'b0;
            r_width       <= '0;
            r_sat_out     <= 1'b0;
            r_overrun     <= 1'b0;
            r_pulse_count <= '0;
`ifdef PULSE_METER_TIMEOUT_EN
            r_timeout     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_ARM: begin
                    if (!sig) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (sig) begin
                        r_state <= S_MEAS;
                        r_cnt   <= WIDTH_W'(1);
                        r_sat   <= 1'b0;
                    end
                end
                S_MEAS: begin
                    if (!sig) begin
                        r_state <= S_IDLE;
                    end else if (w_tmo) begin
                        r_state <= S_ARM;
                    end else if (r_cnt == c_max) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_ARM;
            endcase

            // A new result takes priority over clearing a transferred one.
            if (w_keep) begin
                if (w_free) begin
                    r_valid       <= 1'b1;
                    r_width       <= r_cnt;
                    r_sat_out     <= r_sat;
                    r_pulse_count <= r_pulse_count + 1'b1;
`ifdef PULSE_METER_TIMEOUT_EN
                    r_timeout     <= w_tmo;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o       = r_valid;
    assign width_o       = r_width;
    assign sat_o         = r_sat_out;
    assign overrun_o     = r_overrun;
    assign pulse_count_o = r_pulse_count;

endmodule
`default_nettype wire

// File: tb/tb_pulse_width_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_width_meter
// Description : Directed self-checking bench for pulse_width_meter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_width_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // u0: default parameters
    logic        s0 = 1'b0, rdy0 = 1'b1, v0, sat0, ovr0;
    logic [15:0] w0;
    logic [7:0]  c0;
    // u1: MIN_WIDTH = 3
    logic        s1 = 1'b0, rdy1 = 1'b1, v1, sat1, ovr1;
    logic [15:0] w1;
    logic [7:0]  c1;
    // u2: WIDTH_W = 4
    logic        s2 = 1'b0, rdy2 = 1'b1, v2, sat2, ovr2;
    logic [3:0]  w2;
    logic [7:0]  c2;

    pulse_width_meter u0 (
        .clk(clk), .rst(rst), .sig(s0), .ready_i(rdy0), .valid_o(v0),
        .width_o(w0), .sat_o(sat0), .overrun_o(ovr0), .pulse_count_o(c0)
`ifdef PULSE_METER_TIMEOUT_EN
        , .timeout_o()
`endif
    );

    pulse_width_meter #(.MIN_WIDTH(3)) u1 (
        .clk(clk), .rst(rst), .sig(s1), .ready_i(rdy1), .valid_o(v1),
        .width_o(w1), .sat_o(sat1), .overrun_o(ovr1), .pulse_count_o(c1)
`ifdef PULSE_METER_TIMEOUT_EN
        , .timeout_o()
`endif
    );

    pulse_width_meter #(.WIDTH_W(4)) u2 (
        .clk(clk), .rst(rst), .sig(s2), .ready_i(rdy2), .valid_o(v2),
        .width_o(w2), .sat_o(sat2), .overrun_o(ovr2), .pulse_count_o(c2)
`ifdef PULSE_METER_TIMEOUT_EN
        , .timeout_o()
`endif
    );

`ifdef PULSE_METER_TIMEOUT_EN
    logic        s3 = 1'b0, rdy3 = 1'b1, v3, sat3, ovr3, to3;
    logic [15:0] w3;
    logic [7:0]  c3;

    pulse_width_meter #(.TIMEOUT(8)) u3 (
        .clk(clk), .rst(rst), .sig(s3), .ready_i(rdy3), .valid_o(v3),
        .width_o(w3), .sat_o(sat3), .overrun_o(ovr3), .pulse_count_o(c3),
        .timeout_o(to3)
    );
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_valid", 32'(v0), 0);
        check("rst_width", 32'(w0), 0);
        check("rst_sat", 32'(sat0), 0);
        check("rst_overrun", 32'(ovr0), 0);
        check("rst_count", 32'(c0), 0);
        rst = 1'b0;
        tick(2);

        // Basic 5-edge pulse with ready held high
        s0 = 1'b1; tick(5); s0 = 1'b0; tick(1);
        check("p5_valid", 32'(v0), 1);
        check("p5_width", 32'(w0), 5);
        check("p5_sat", 32'(sat0), 0);
        check("p5_count", 32'(c0), 1);
        tick(1);
        check("p5_valid_drop", 32'(v0), 0);
        check("p5_width_hold", 32'(w0), 5);

        // MIN_WIDTH=3: a 2-edge glitch is dropped, a 3-edge pulse is kept
        s1 = 1'b1; tick(2); s1 = 1'b0; tick(1);
        check("glitch_valid", 32'(v1), 0);
        check("glitch_count", 32'(c1), 0);
        s1 = 1'b1; tick(3); s1 = 1'b0; tick(1);
        check("min_valid", 32'(v1), 1);
        check("min_width", 32'(w1), 3);
        check("min_count", 32'(c1), 1);

        // WIDTH_W=4 saturation on a 20-edge pulse
        s2 = 1'b1; tick(20); s2 = 1'b0; tick(1);
        check("sat_valid", 32'(v2), 1);
        check("sat_width", 32'(w2), 15);
        check("sat_flag", 32'(sat2), 1);

        // Overrun with ready low
        rdy0 = 1'b0;
        s0 = 1'b1; tick(4); s0 = 1'b0; tick(1);
        check("ov_first_width", 32'(w0), 4);
        check("ov_first_count", 32'(c0), 2);
        s0 = 1'b1; tick(6); s0 = 1'b0; tick(1);
        check("ov_valid", 32'(v0), 1);
        check("ov_width_held", 32'(w0), 4);
        check("ov_flag", 32'(ovr0), 1);
        check("ov_count", 32'(c0), 2);
        rdy0 = 1'b1; tick(1);
        check("ov_xfer_valid", 32'(v0), 0);
        check("ov_sticky", 32'(ovr0), 1);

        // Reset mid-pulse, release with sig still high
        s0 = 1'b1; tick(3);
        rst = 1'b1; tick(1);
        check("mid_rst_overrun", 32'(ovr0), 0);
        check("mid_rst_count", 32'(c0), 0);
        check("mid_rst_width", 32'(w0), 0);
        rst = 1'b0; tick(3);
        s0 = 1'b0; tick(1);
        check("armed_no_result", 32'(v0), 0);
        rdy0 = 1'b0;
        s0 = 1'b1; tick(2); s0 = 1'b0; tick(1);
        check("post_rst_valid", 32'(v0), 1);
        check("post_rst_width", 32'(w0), 2);
        check("post_rst_count", 32'(c0), 1);

        // Transfer and completion on the same edge: the new result loads
        s0 = 1'b1; tick(7); s0 = 1'b0; rdy0 = 1'b1; tick(1);
        check("same_edge_valid", 32'(v0), 1);
        check("same_edge_width", 32'(w0), 7);
        check("same_edge_count", 32'(c0), 2);
        check("same_edge_no_ovr", 32'(ovr0), 0);
        tick(1);
        check("same_edge_drain", 32'(v0), 0);

`ifdef PULSE_METER_TIMEOUT_EN
        begin
            int extra;
            extra = 0;
            s3 = 1'b1; tick(9);
            check("tmo_valid", 32'(v3), 1);
            check("tmo_width", 32'(w3), 8);
            check("tmo_flag", 32'(to3), 1);
            check("tmo_count", 32'(c3), 1);
            repeat (21) begin
                tick(1);
                if (v3) extra++;
            end
            check("tmo_no_more", 32'(extra), 0);
            check("tmo_count_hold", 32'(c3), 1);
            s3 = 1'b0; tick(1);
            s3 = 1'b1; tick(3); s3 = 1'b0; tick(1);
            check("tmo_next_width", 32'(w3), 3);
            check("tmo_next_flag", 32'(to3), 0);
            check("tmo_next_count", 32'(c3), 2);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
- Receiver/measurer for single-signal level pulses: samples a synchronous input, counts how many clock edges it is held high, and presents each completed width on a valid/ready output register.
- RTL counterpart to the bench-side pulse driver, which holds a signal high for N clock edges and then drops it.
- Used in-core to time strobe/handshake pulses, and by benches as a self-checking monitor.

Parameters:
- WIDTH_W, 16, bit width of the width counter and of width_o.
- MIN_WIDTH, 1, completed pulses with width < MIN_WIDTH are discarded as glitches (legal range 1..2^WIDTH_W-1).
- COUNT_W, 8, bit width of pulse_count_o.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sig  in  1  measured signal, already synchronous to clk.
- ready_i  in  1  consumer accepts the result when valid_o && ready_i at posedge.
- valid_o  out  1  result register holds an unconsumed measurement.
- width_o  out  WIDTH_W  measured high time in clk edges.
- sat_o  out  1  qualifies width_o: the count saturated at 2^WIDTH_W-1.
- overrun_o  out  1  sticky: a completed pulse was dropped because the result register was full.
- pulse_count_o  out  COUNT_W  number of results loaded into the output register; wraps modulo 2^COUNT_W.

Behaviour:
- Reset: state=ARM, cnt=0, valid_o=0, width_o=0, sat_o=0, overrun_o=0, pulse_count_o=0. Reset asserted mid-pulse or with a pending result discards both.
- FSM states ARM, IDLE, MEAS. All decisions use sig as sampled at the posedge.
- ARM: waits for sig=0, then goes to IDLE. A pulse already high when reset releases is never measured.
- IDLE, sig=1: go to MEAS with cnt=1.
- IDLE, sig=0: remain in IDLE.
- MEAS, sig=1: cnt=cnt+1, saturating at 2^WIDTH_W-1. The saturation flag is latched internally.
- MEAS, sig=0: the pulse is complete with width=cnt. Go to IDLE on the same edge.
- Width definition: number of consecutive posedges at which sig was sampled 1. A driver holding sig high across N posedges yields width N.
- A back-to-back pulse needs at least one low sample. The same edge that ends a pulse cannot start the next one.
- Completion on edge E:
  - width < MIN_WIDTH: the pulse is dropped silently. No counter, flag or output changes.
  - Otherwise, if the result register is free (valid_o=0, or valid_o&&ready_i on E): width_o, sat_o and valid_o=1 are loaded on E, and pulse_count_o increments.
  - Latency: valid_o is visible in the cycle after the first low sample.
- Simultaneous transfer and completion: load wins. valid_o stays 1 and carries the new width.
- Completion while valid_o=1 && !ready_i: the new result is dropped, the old result is held unchanged, and overrun_o is set. overrun_o clears only on rst.
- Transfer with no completion on that edge: valid_o=0 on the next cycle. width_o and sat_o keep their last values.
- ready_i has no effect while valid_o=0. valid_o never depends combinationally on ready_i.

Optional Feature:
- PULSE_METER_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 1000) and output timeout_o (1 bit), which qualifies width_o.
  - In MEAS, when cnt reaches TIMEOUT with sig still 1, a result is emitted with width=TIMEOUT and timeout_o=1. It follows the same load/drop/overrun rules as a normal completion.
  - The FSM then goes to ARM, so the remainder of the stuck-high pulse is ignored until sig=0.
- When undefined:
  - No TIMEOUT parameter and no timeout_o port.
  - Pulses are measured indefinitely, with saturation as the only long-pulse indication.

Test Plan:
- Hold ready_i=1, then drive sig high for 5 edges followed by low → one valid_o cycle with width_o=5, sat_o=0, and pulse_count_o goes 0→1.
- MIN_WIDTH=3, pulses of 2 then 3 edges → only one result, width_o=3; pulse_count_o=1.
- WIDTH_W=4, pulse of 20 edges → width_o=15, sat_o=1.
- ready_i=0:
  - Pulse of 4 edges, then pulse of 6 edges → valid_o held with width_o=4 and overrun_o=1.
  - Then raise ready_i → one transfer of 4, and overrun_o stays 1.
- Reset cases:
  - Assert rst while sig is high in mid-pulse, then release with sig still high for 3 more edges → no result.
  - The next 2-edge pulse → width_o=2.
- PULSE_METER_TIMEOUT_EN defined with TIMEOUT=8, sig held high for 30 edges → one result with width_o=8 and timeout_o=1, and no further result until sig falls and a new pulse completes.
